// File: rtl/bus_copy_master.sv
// bus_copy_master: second bus initiator that copies len 32-bit words from a
// source address to a destination address over the valid/ready peripheral
// bus. Each word is one read then one write. A low cycle separates any two
// transactions, so responders that raise ready one cycle after valid work.
module bus_copy_master #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             src_inc,
    input  logic             dst_inc,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             valid,
    input  logic             ready,
    output logic [31:0]      addr,
    input  logic [31:0]      rdata,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb
);

    typedef enum logic [2:0] {IDLE, READ, RGAP, WRITE, WGAP} state_t;

    // Wide enough to hold TIMEOUT-1; one bit minimum so the counter is legal
    // even when the timeout is disabled.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t           state, state_nx;
    logic [31:0]      src_ptr, dst_ptr;
    logic [31:0]      src_next, dst_next;
    logic [LEN_W-1:0] remaining;
    logic             src_inc_q, dst_inc_q;
    logic [TW-1:0]    wait_cnt;
    logic             timed_out;
    logic             last_word;

    // valid and busy decode the state register directly, so they are glitch
    // free and drop in the first cycle after reset or after an abort.
    assign valid     = (state == READ) || (state == WRITE);
    assign busy      = (state != IDLE);
    assign last_word = (remaining == LEN_W'(1));
    assign timed_out = (TIMEOUT != 0) && valid && !ready &&
                       (wait_cnt == TW'(TIMEOUT - 1));
    // +4 wraps naturally modulo 2^32; unaligned pointers are never adjusted.
    assign src_next  = src_inc_q ? src_ptr + 32'd4 : src_ptr;
    assign dst_next  = dst_inc_q ? dst_ptr + 32'd4 : dst_ptr;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic: one read, one gap, one write, one gap per word.
    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch
        // is inferred.
        state_nx = state;
        case (state)
            IDLE:    if (start && (len != '0)) state_nx = READ;
            READ:    if (timed_out)            state_nx = IDLE;
                     else if (ready)           state_nx = RGAP;
            RGAP:                              state_nx = WRITE;
            WRITE:   if (timed_out)            state_nx = IDLE;
                     else if (ready)           state_nx = last_word ? IDLE : WGAP;
            WGAP:                              state_nx = READ;
            default:                           state_nx = IDLE;
        endcase
    end

    // Datapath: latch the job, hold bus fields stable, step pointers and count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr      <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            done     <= 1'b0;
            // Counts stalled cycles of the current transaction; gaps clear it,
            // so it restarts on every entry to READ or WRITE.
            wait_cnt <= (valid && !ready) ? wait_cnt + TW'(1) : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= len;
                        src_inc_q <= src_inc;
                        dst_inc_q <= dst_inc;
                        error     <= 1'b0;
                        addr      <= src_addr;
                        wstrb     <= 4'h0;
                        if (len == '0) done <= 1'b1;
                    end
                end
                READ: begin
                    if (timed_out) begin
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else if (ready) begin
                        // wdata doubles as the data register: loaded here and
                        // already stable when the write goes out.
                        wdata <= rdata;
                        addr  <= dst_ptr;
                        wstrb <= 4'hF;
                    end
                end
                WRITE: begin
                    if (timed_out) begin
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else if (ready) begin
                        src_ptr   <= src_next;
                        dst_ptr   <= dst_next;
                        remaining <= remaining - LEN_W'(1);
                        if (last_word) begin
                            done <= 1'b1;
                        end else begin
                            addr  <= src_next;
                            wstrb <= 4'h0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_copy_master.sv
// Directed bench for bus_copy_master: a 1-cycle responder model, a passive
// bus monitor logging handshakes and done pulses, and one task per scenario.
module tb_bus_copy_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
    logic        src_inc, dst_inc;
    logic        busy, done, error, valid;
    logic        ready = 1'b0;
    logic [31:0] addr;
    logic [31:0] rdata = '0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int s_cyc = 0;
    bit resp_on = 1'b1;
    int gpio_cnt = 0;

    // monitor logs (written only by the monitor)
    logic [31:0] rd_addr[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          v_cyc[$];
    int          d_cyc[$];
    int          proto_viol = 0;
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pa = '0, pw = '0;
    logic [3:0]  ps = '0;

    // per-test baselines (written only by the initial process)
    int rd_base, wr_base, v_base, d_base;

    bus_copy_master #(.LEN_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .src_inc(src_inc), .dst_inc(dst_inc),
        .busy(busy), .done(done), .error(error),
        .valid(valid), .ready(ready), .addr(addr),
        .rdata(rdata), .wdata(wdata), .wstrb(wstrb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: raises ready one cycle after valid; reads come from a small
    // memory map, 0x1000 is a GPIO input returning 1,2,3,...
    always @(posedge clk) begin
        if (resp_on && valid && !ready) begin
            ready <= 1'b1;
            if (wstrb == 4'h0) begin
                case (addr)
                    32'h0000_0100: rdata <= 32'hA;
                    32'h0000_0104: rdata <= 32'hB;
                    32'h0000_0108: rdata <= 32'hC;
                    32'hFFFF_FFFC: rdata <= 32'h55;
                    32'h0000_0000: rdata <= 32'h66;
                    32'h0000_1000: begin
                        rdata    <= 32'(gpio_cnt + 1);
                        gpio_cnt <= gpio_cnt + 1;
                    end
                    default:       rdata <= {16'hDEAD, addr[15:0]};
                endcase
            end
        end else begin
            ready <= 1'b0;
        end
    end

    // Monitor: samples mid-cycle, logs traffic and checks bus stability rules.
    always @(negedge clk) begin
        if (valid) v_cyc.push_back(cyc);
        if (done)  d_cyc.push_back(cyc);
        if (valid && ready) begin
            if (wstrb == 4'h0) rd_addr.push_back(addr);
            else begin
                wr_addr.push_back(addr);
                wr_data.push_back(wdata);
            end
        end
        if (pv && !pr && valid && (addr !== pa || wdata !== pw || wstrb !== ps))
            proto_viol++;
        if (pv && pr && valid) proto_viol++;
        pv = valid; pr = ready; pa = addr; pw = wdata; ps = wstrb;
    end

    task automatic snap_bases();
        rd_base = rd_addr.size();
        wr_base = wr_addr.size();
        v_base  = v_cyc.size();
        d_base  = d_cyc.size();
    endtask

    // Drives start for one cycle; the cycle it is driven in is cycle 0.
    task automatic start_copy(input logic [31:0] s_a, input logic [31:0] d_a,
                              input logic [15:0] n, input logic si, input logic di);
        snap_bases();
        @(negedge clk);
        src_addr = s_a; dst_addr = d_a; len = n; src_inc = si; dst_inc = di;
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (d_cyc.size() < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (d_cyc.size() < target) begin
            errors++;
            $display("FAIL done_wait: got %0d done pulses required %0d", d_cyc.size(), target);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1;
        src_addr = 32'h100; dst_addr = 32'h200; len = 16'd3; src_inc = 1'b1; dst_inc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk); #1;
            checks++;
            if ({valid, busy, done, error, wstrb, addr} !== 40'h0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got v%b b%b d%b e%b s%h a%h required all zero",
                         i, valid, busy, done, error, wstrb, addr);
            end
        end
        start = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mem_copy();
        logic [31:0] e_rd[3] = '{32'h100, 32'h104, 32'h108};
        logic [31:0] e_wa[3] = '{32'h200, 32'h204, 32'h208};
        logic [31:0] e_wd[3] = '{32'hA, 32'hB, 32'hC};
        start_copy(32'h100, 32'h200, 16'd3, 1'b1, 1'b1);
        wait_done(d_base + 1, 40);
        checks++;
        if (d_cyc[d_base] - s_cyc !== 18) begin
            errors++; $display("FAIL mem_done_cycle: got %0d required 18", d_cyc[d_base] - s_cyc);
        end
        checks++;
        if (v_cyc[v_base] - s_cyc !== 1 || v_cyc.size() - v_base !== 12) begin
            errors++; $display("FAIL mem_valid_timing: first %0d count %0d required 1 and 12",
                               v_cyc[v_base] - s_cyc, v_cyc.size() - v_base);
        end
        checks++;
        if (rd_addr.size() - rd_base !== 3 || wr_addr.size() - wr_base !== 3) begin
            errors++; $display("FAIL mem_txn_count: got %0d reads %0d writes required 3 and 3",
                               rd_addr.size() - rd_base, wr_addr.size() - wr_base);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_addr[rd_base+i] !== e_rd[i] || wr_addr[wr_base+i] !== e_wa[i] ||
                wr_data[wr_base+i] !== e_wd[i]) begin
                errors++; $display("FAIL mem_word[%0d]: got rd %h wr %h=%h required rd %h wr %h=%h", i,
                                   rd_addr[rd_base+i], wr_addr[wr_base+i], wr_data[wr_base+i],
                                   e_rd[i], e_wa[i], e_wd[i]);
            end
        end
        checks++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL mem_end_flags: got busy %b error %b required 0 0", busy, error);
        end
    endtask

    task automatic test_gpio_bridge();
        start_copy(32'h1000, 32'h2000, 16'd4, 1'b0, 1'b0);
        wait_done(d_base + 1, 50);
        checks++;
        if (d_cyc[d_base] - s_cyc !== 24) begin
            errors++; $display("FAIL gpio_done_cycle: got %0d required 24", d_cyc[d_base] - s_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_addr[rd_base+i] !== 32'h1000 || wr_addr[wr_base+i] !== 32'h2000 ||
                wr_data[wr_base+i] !== 32'(i + 1)) begin
                errors++; $display("FAIL gpio_word[%0d]: got rd %h wr %h=%h required rd 1000 wr 2000=%0d", i,
                                   rd_addr[rd_base+i], wr_addr[wr_base+i], wr_data[wr_base+i], i + 1);
            end
        end
    endtask

    task automatic test_zero_and_wrap();
        int b0;
        start_copy(32'h100, 32'h700, 16'd0, 1'b1, 1'b1);
        b0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (busy) b0++;
        end
        checks++;
        if (d_cyc.size() - d_base !== 1 || d_cyc[d_base] - s_cyc !== 1) begin
            errors++; $display("FAIL zero_done: got %0d pulses first at %0d required 1 at 1",
                               d_cyc.size() - d_base, d_cyc[d_base] - s_cyc);
        end
        checks++;
        if (v_cyc.size() - v_base !== 0 || b0 !== 0) begin
            errors++; $display("FAIL zero_no_traffic: got %0d valid cycles busy %0d required 0 0",
                               v_cyc.size() - v_base, b0);
        end
        start_copy(32'hFFFF_FFFC, 32'h800, 16'd2, 1'b1, 1'b1);
        wait_done(d_base + 1, 40);
        checks++;
        if (rd_addr[rd_base] !== 32'hFFFF_FFFC || rd_addr[rd_base+1] !== 32'h0 ||
            rd_addr.size() - rd_base !== 2) begin
            errors++; $display("FAIL wrap_src_addr: got %h %h required fffffffc 00000000",
                               rd_addr[rd_base], rd_addr[rd_base+1]);
        end
        checks++;
        if (wr_addr[wr_base] !== 32'h800 || wr_addr[wr_base+1] !== 32'h804 ||
            wr_data[wr_base] !== 32'h55 || wr_data[wr_base+1] !== 32'h66) begin
            errors++; $display("FAIL wrap_writes: got %h=%h %h=%h required 800=55 804=66",
                               wr_addr[wr_base], wr_data[wr_base], wr_addr[wr_base+1], wr_data[wr_base+1]);
        end
    endtask

    task automatic test_timeout();
        resp_on = 1'b0;
        start_copy(32'h100, 32'h900, 16'd1, 1'b1, 1'b1);
        wait_done(d_base + 1, 40);
        checks++;
        if (v_cyc[v_base] - s_cyc !== 1 || v_cyc[v_cyc.size()-1] - s_cyc !== 8 ||
            v_cyc.size() - v_base !== 8) begin
            errors++; $display("FAIL timeout_valid_window: got first %0d last %0d count %0d required 1 8 8",
                               v_cyc[v_base] - s_cyc, v_cyc[v_cyc.size()-1] - s_cyc, v_cyc.size() - v_base);
        end
        checks++;
        if (d_cyc[d_base] - s_cyc !== 9 || error !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
            errors++; $display("FAIL timeout_abort: got done at %0d error %b busy %b valid %b required 9 1 0 0",
                               d_cyc[d_base] - s_cyc, error, busy, valid);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (error !== 1'b1) begin
            errors++; $display("FAIL timeout_error_held: got %b required 1", error);
        end
        resp_on = 1'b1;
        start_copy(32'h100, 32'h900, 16'd0, 1'b1, 1'b1);
        checks++;
        if (error !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL timeout_error_clear: got error %b done %b required 0 1", error, done);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        snap_bases();
        @(negedge clk);
        src_addr = 32'h100; dst_addr = 32'h600; len = 16'd1; src_inc = 1'b1; dst_inc = 1'b1;
        start = 1'b1;
        s_cyc = cyc;
        wait_done(d_base + 2, 40);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (d_cyc.size() - d_base !== 2 || d_cyc[d_base] - s_cyc !== 6 || d_cyc[d_base+1] - s_cyc !== 12) begin
            errors++; $display("FAIL b2b_done: got %0d pulses at %0d %0d required 2 at 6 12",
                               d_cyc.size() - d_base, d_cyc[d_base] - s_cyc, d_cyc[d_base+1] - s_cyc);
        end
        checks++;
        if (wr_addr.size() - wr_base !== 2 || wr_addr[wr_base+1] !== 32'h600 || wr_data[wr_base+1] !== 32'hA) begin
            errors++; $display("FAIL b2b_writes: got %0d writes last %h=%h required 2 last 600=a",
                               wr_addr.size() - wr_base, wr_addr[wr_base+1], wr_data[wr_base+1]);
        end
    endtask

    task automatic test_abuse();
        int n;
        start_copy(32'h100, 32'h300, 16'd2, 1'b1, 1'b1);
        @(negedge clk);
        src_addr = 32'h900; dst_addr = 32'hA00; len = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d_base + 1, 40);
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (d_cyc.size() - d_base !== 1 || d_cyc[d_base] - s_cyc !== 12) begin
            errors++; $display("FAIL abuse_len_kept: got %0d pulses first at %0d required 1 at 12",
                               d_cyc.size() - d_base, d_cyc[d_base] - s_cyc);
        end
        checks++;
        if (rd_addr.size() - rd_base !== 2 || rd_addr[rd_base+1] !== 32'h104 ||
            wr_addr[wr_base+1] !== 32'h304 || wr_data[wr_base+1] !== 32'hB) begin
            errors++; $display("FAIL abuse_no_relatch: got %0d reads last rd %h wr %h=%h required 2 104 304=b",
                               rd_addr.size() - rd_base, rd_addr[rd_base+1], wr_addr[wr_base+1], wr_data[wr_base+1]);
        end
        // reset in the middle of the first write
        start_copy(32'h100, 32'h500, 16'd3, 1'b1, 1'b1);
        n = 0;
        while (!(valid && wstrb == 4'hF) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (!(valid && wstrb == 4'hF)) begin
            errors++; $display("FAIL abuse_reach_write: got valid %b wstrb %h required 1 f", valid, wstrb);
        end
        reset_n = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abuse_reset_abort: got valid %b busy %b done %b required 0 0 0",
                               valid, busy, done);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (d_cyc.size() - d_base !== 0 || wr_addr.size() - wr_base !== 0) begin
            errors++; $display("FAIL abuse_reset_no_done: got %0d done %0d writes required 0 0",
                               d_cyc.size() - d_base, wr_addr.size() - wr_base);
        end
    endtask

    initial begin
        test_reset();
        test_mem_copy();
        test_gpio_bridge();
        test_zero_and_wrap();
        test_timeout();
        test_back_to_back();
        test_abuse();
        checks++;
        if (proto_viol !== 0) begin
            errors++; $display("FAIL bus_protocol: got %0d violations required 0", proto_viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
